// File: rtl/vga_plot_arbiter.sv
// vga_plot_arbiter: shares the VGA adapter pixel write port among draw engines.
// Define ARB_ROUND_ROBIN_EN for round-robin selection; default is fixed priority.
`timescale 1ns/1ps
module vga_plot_arbiter #(
    parameter int NREQ    = 3,
    parameter int XW      = 8,
    parameter int YW      = 7,
    parameter int CW      = 3,
    parameter int TIMEOUT = 1024
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ-1:0]    done,
    input  logic [NREQ*XW-1:0] pix_x,
    input  logic [NREQ*YW-1:0] pix_y,
    input  logic [NREQ*CW-1:0] pix_col,
    input  logic [NREQ-1:0]    pix_valid,
    output logic [NREQ-1:0]    grant,
    output logic               busy,
    output logic [XW-1:0]      vga_x,
    output logic [YW-1:0]      vga_y,
    output logic [CW-1:0]      vga_colour,
    output logic               vga_plot,
    output logic               timeout_err
);

    localparam int IW   = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CNTW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE,
        OWN,
        RELEASE
    } state_t;

    state_t          state;
    logic [IW-1:0]   owner;
    logic [IW-1:0]   win;
    logic [CNTW-1:0] idle_cnt;
    logic            own_valid;
    logic            own_done;
    logic            expired;

    assign own_valid = pix_valid[owner];
    assign own_done  = done[owner];
    assign expired   = (idle_cnt == CNTW'(TIMEOUT - 1));
    assign busy      = |grant;

`ifdef ARB_ROUND_ROBIN_EN
    logic [IW-1:0] rr_ptr;
    logic          hit;
    int            idx;

    // Cyclic search for the first request at or after rr_ptr
    always_comb begin
        win = '0;
        hit = 1'b0;
        idx = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(rr_ptr) + k) % NREQ;
            if (!hit && req[idx]) begin
                win = IW'(idx);
                hit = 1'b1;
            end
        end
    end
`else
    always_comb begin
        win = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req[k]) win = IW'(k);
        end
    end
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            owner       <= '0;
            idle_cnt    <= '0;
            grant       <= '0;
            vga_x       <= '0;
            vga_y       <= '0;
            vga_colour  <= '0;
            vga_plot    <= 1'b0;
            timeout_err <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            rr_ptr      <= '0;
`endif
        end else begin
            vga_plot    <= 1'b0;
            timeout_err <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (|req) begin
                        owner    <= win;
                        grant    <= NREQ'(1) << win;
                        idle_cnt <= '0;
                        state    <= OWN;
                    end
                end
                OWN: begin
                    vga_plot <= own_valid;
                    if (own_valid) begin
                        vga_x      <= pix_x[owner*XW +: XW];
                        vga_y      <= pix_y[owner*YW +: YW];
                        vga_colour <= pix_col[owner*CW +: CW];
                        idle_cnt   <= '0;
                    end else if (idle_cnt != '1) begin
                        idle_cnt <= idle_cnt + 1'b1;
                    end
                    // A silent owner is evicted exactly as if it had signalled done
                    if (own_done || expired) begin
                        grant       <= '0;
                        timeout_err <= !own_done;
                        state       <= RELEASE;
`ifdef ARB_ROUND_ROBIN_EN
                        if (owner == IW'(NREQ - 1)) rr_ptr <= '0;
                        else                        rr_ptr <= owner + 1'b1;
`endif
                    end
                end
                RELEASE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vga_plot_arbiter.sv
// tb_vga_plot_arbiter: directed scenarios plus randomized traffic
// checked cycle by cycle against a transaction-level reference model.
`timescale 1ns/1ps
module tb_vga_plot_arbiter;

    localparam int NREQ    = 3;
    localparam int XW      = 8;
    localparam int YW      = 7;
    localparam int CW      = 3;
    localparam int TIMEOUT = 8;

    logic               clock = 1'b0;
    logic               reset;
    logic [NREQ-1:0]    req;
    logic [NREQ-1:0]    done;
    logic [NREQ*XW-1:0] pix_x;
    logic [NREQ*YW-1:0] pix_y;
    logic [NREQ*CW-1:0] pix_col;
    logic [NREQ-1:0]    pix_valid;
    logic [NREQ-1:0]    grant;
    logic               busy;
    logic [XW-1:0]      vga_x;
    logic [YW-1:0]      vga_y;
    logic [CW-1:0]      vga_colour;
    logic               vga_plot;
    logic               timeout_err;

    always #5 clock = ~clock;

    vga_plot_arbiter #(
        .NREQ(NREQ), .XW(XW), .YW(YW), .CW(CW), .TIMEOUT(TIMEOUT)
    ) dut (
        .clock(clock), .reset(reset), .req(req), .done(done),
        .pix_x(pix_x), .pix_y(pix_y), .pix_col(pix_col),
        .pix_valid(pix_valid), .grant(grant), .busy(busy),
        .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour),
        .vga_plot(vga_plot), .timeout_err(timeout_err)
    );

    int n_chk  = 0;
    int n_pass = 0;

    // Model: owner index (-1 = none), dead flag, last activity stamp
    int          m_own = -1;
    bit          m_dead = 1'b0;
    int          m_rr = 0;
    int          m_act = 0;
    int          now = 0;
    logic [XW-1:0] m_x = '0;
    logic [YW-1:0] m_y = '0;
    logic [CW-1:0] m_c = '0;
    logic        m_plot = 1'b0;
    logic        m_terr = 1'b0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)",
                      tag, got, exp, $time);
    endtask

    function automatic int pick(input logic [NREQ-1:0] r);
`ifdef ARB_ROUND_ROBIN_EN
        for (int k = 0; k < NREQ; k++)
            if (r[(m_rr + k) % NREQ]) return (m_rr + k) % NREQ;
`else
        for (int k = 0; k < NREQ; k++)
            if (r[k]) return k;
`endif
        return -1;
    endfunction

    task automatic model_step();
        int o;
        if (reset) begin
            m_own = -1; m_dead = 1'b0; m_rr = 0;
            m_x = '0; m_y = '0; m_c = '0;
            m_plot = 1'b0; m_terr = 1'b0;
        end else begin
            m_plot = 1'b0;
            m_terr = 1'b0;
            if (m_dead) begin
                m_dead = 1'b0;
            end else if (m_own < 0) begin
                if (req != '0) begin
                    m_own = pick(req);
                    m_act = now + 1;
                end
            end else begin
                o = m_own;
                m_plot = pix_valid[o];
                if (pix_valid[o]) begin
                    m_x = pix_x[o*XW +: XW];
                    m_y = pix_y[o*YW +: YW];
                    m_c = pix_col[o*CW +: CW];
                end
                if (done[o] || (now - m_act == TIMEOUT - 1)) begin
                    m_terr = !done[o];
                    m_own  = -1;
                    m_dead = 1'b1;
                    m_rr   = (o + 1) % NREQ;
                end else if (pix_valid[o]) begin
                    m_act = now + 1;
                end
            end
        end
        now++;
    endtask

    task automatic tick();
        logic [NREQ-1:0] eg;
        model_step();
        @(posedge clock);
        #1;
        eg = (m_own >= 0) ? NREQ'(1) << m_own : '0;
        check("grant", 32'(grant), 32'(eg));
        check("busy", 32'(busy), 32'(m_own >= 0));
        check("plot", 32'(vga_plot), 32'(m_plot));
        check("terr", 32'(timeout_err), 32'(m_terr));
        check("xyc", {13'd0, vga_x, vga_y, vga_colour},
              {13'd0, m_x, m_y, m_c});
    endtask

    task automatic clear_in();
        req = '0; done = '0; pix_valid = '0;
    endtask

    task automatic set_pix(input int i, input int x, input int y, input int c);
        pix_x[i*XW +: XW]   = XW'(x);
        pix_y[i*YW +: YW]   = YW'(y);
        pix_col[i*CW +: CW] = CW'(c);
    endtask

    initial begin
        int plots;
        int hi;
        int terrs;
        reset = 1'b1;
        pix_x = '0; pix_y = '0; pix_col = '0;
        clear_in();
        tick();
        tick();
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_plot", 32'(vga_plot), 32'd0);
        reset = 1'b0;
        tick();

        // Engine 0: four pixels then done
        req = 3'b001;
        tick();
        check("t1_grant", 32'(grant), 32'b001);
        req = '0;
        plots = 0;
        for (int i = 0; i < 4; i++) begin
            pix_valid = 3'b001;
            set_pix(0, 10 + i, 20 + i, i);
            tick();
            if (vga_plot) plots++;
        end
        pix_valid = '0;
        done = 3'b001;
        tick();
        if (vga_plot) plots++;
        done = '0;
        for (int i = 0; i < 2; i++) begin
            tick();
            if (vga_plot) plots++;
        end
        check("t1_plots", 32'(plots), 32'd4);
        check("t1_busy", 32'(busy), 32'd0);

        // Simultaneous car and erase requests
        req = 3'b110;
        tick();
        check("t2_first", 32'(grant), 32'b010);
        tick();
        done = 3'b010;
        req = 3'b100;
        tick();
        done = '0;
        for (int i = 0; i < 6 && grant == '0; i++) tick();
        check("t2_second", 32'(grant), 32'b100);
        req = '0;
        done = 3'b100;
        tick();
        done = '0;
        tick();
        tick();

        // Silent owner is evicted by the idle timeout
        req = 3'b100;
        tick();
        req = '0;
        hi = grant[2] ? 1 : 0;
        terrs = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (grant[2]) hi++;
            if (timeout_err) terrs++;
        end
        check("t3_hold", 32'(hi), 32'(TIMEOUT));
        check("t3_terr", 32'(terrs), 32'd1);
        req = 3'b001;
        tick();
        check("t3_next", 32'(grant), 32'b001);
        req = '0;
        done = 3'b001;
        tick();
        done = '0;
        tick();
        tick();

        // Reset in the middle of a burst
        req = 3'b010;
        tick();
        pix_valid = 3'b010;
        set_pix(1, 77, 55, 5);
        tick();
        check("t4_plot", 32'(vga_plot), 32'd1);
        reset = 1'b1;
        tick();
        check("t4_grant", 32'(grant), 32'd0);
        check("t4_x", 32'(vga_x), 32'd0);
        reset = 1'b0;
        pix_valid = '0;
        req = 3'b001;
        tick();
        check("t4_regrant", 32'(grant), 32'b001);

        // Non-owner pixels must not reach the adapter
        req = '0;
        pix_valid = 3'b001;
        set_pix(0, 37, 11, 2);
        tick();
        pix_valid = 3'b010;
        set_pix(1, 159, 119, 7);
        tick();
        check("t5_plot", 32'(vga_plot), 32'd0);
        check("t5_x", 32'(vga_x), 32'd37);
        pix_valid = '0;
        done = 3'b001;
        tick();
        clear_in();
        tick();
        tick();

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(0, 299) == 0);
            req = NREQ'($urandom);
            for (int k = 0; k < NREQ; k++) begin
                done[k]      = ($urandom_range(0, 5) == 0);
                pix_valid[k] = ($urandom_range(0, 3) == 0);
            end
            pix_x   = (NREQ*XW)'($urandom);
            pix_y   = (NREQ*YW)'($urandom);
            pix_col = (NREQ*CW)'($urandom);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
